// File: rtl/bcd_score_tracker.sv
// BCD score tracker: tick-driven score with bonus adds, saturation,
// high-score capture at game over and a display mux.
module bcd_score_tracker #(
    parameter int DIGITS   = 3,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                alive,
    input  logic                pause,
    input  logic                bonus_valid,
    input  logic [3:0]          bonus_amt,
    input  logic                clear_high,
    input  logic                show_high,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic [4*DIGITS-1:0] high_bcd,
    output logic [4*DIGITS-1:0] disp_bcd,
    output logic                tick,
    output logic                new_high,
    output logic                saturated,
    output logic [1:0]          state
);

    localparam int W  = 4 * DIGITS;
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
    localparam logic [W-1:0]  ALL9    = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t        cur, nxt;
    logic [DW-1:0] div_q, div_d;
    logic [W-1:0]  score_q, score_d;
    logic [W-1:0]  high_q, high_d;
    logic [W-1:0]  sum;
    logic          new_high_q, new_high_d;
    logic          sat_q, sat_d;
    logic          upd;
    logic [3:0]    bonus;
    logic [4:0]    inc;
    logic [4:0]    dsum;
    logic          carry;

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE:    if (alive)  nxt = RUN;
            RUN:     if (!alive) nxt = OVER;
            OVER:    if (alive)  nxt = RUN;
            default: nxt = IDLE;
        endcase
    end

    assign tick  = (cur == RUN) && !pause && (div_q == DIV_MAX);
    assign bonus = (bonus_amt > 4'd9) ? 4'd9 : bonus_amt;
    assign inc   = {4'b0, tick} + (bonus_valid ? {1'b0, bonus} : 5'd0);

    // Increment is at most 10, so the carry into each digit is at most 1.
    always_comb begin
        sum   = score_q;
        carry = 1'b0;
        dsum  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dsum = {1'b0, score_q[4*i +: 4]} + ((i == 0) ? inc : {4'b0, carry});
            if (dsum > 5'd9) begin
                sum[4*i +: 4] = 4'(dsum - 5'd10);
                carry         = 1'b1;
            end else begin
                sum[4*i +: 4] = dsum[3:0];
                carry         = 1'b0;
            end
        end
        if (carry) sum = ALL9;
    end

    always_comb begin
        score_d = score_q;
        div_d   = '0;
        upd     = 1'b0;
        if (cur == RUN) begin
            score_d = sum;
            if (pause)     div_d = div_q;
            else if (tick) div_d = '0;
            else           div_d = div_q + DW'(1);
            upd = !alive && (sum > high_q);
        end else if (alive) begin
            score_d = '0;
        end
        high_d     = clear_high ? '0 : (upd ? sum : high_q);
        new_high_d = upd && !clear_high;
        sat_d      = (score_d == ALL9);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur        <= IDLE;
            div_q      <= '0;
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            cur        <= nxt;
            div_q      <= div_d;
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
            sat_q      <= sat_d;
        end
    end

    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign disp_bcd  = show_high ? high_q : score_q;
    assign new_high  = new_high_q;
    assign saturated = sat_q;
    assign state     = cur;

endmodule

// File: tb/tb_bcd_score_tracker.sv
// Directed bench for bcd_score_tracker with a decimal reference model
// and a scoreboard of expected post-edge values.
module tb_bcd_score_tracker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alive = 1'b0;
    logic        pause = 1'b0;
    logic        bonus_valid = 1'b0;
    logic [3:0]  bonus_amt = 4'd0;
    logic        clear_high = 1'b0;
    logic        show_high = 1'b0;
    logic [11:0] score_bcd, high_bcd, disp_bcd;
    logic        tick, new_high, saturated;
    logic [1:0]  state;

    bcd_score_tracker #(.DIGITS(3), .TICK_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .alive(alive), .pause(pause),
        .bonus_valid(bonus_valid), .bonus_amt(bonus_amt),
        .clear_high(clear_high), .show_high(show_high),
        .score_bcd(score_bcd), .high_bcd(high_bcd), .disp_bcd(disp_bcd),
        .tick(tick), .new_high(new_high), .saturated(saturated),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int score;
        int high;
        int nh;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int m_st = 0, m_score = 0, m_high = 0, m_div = 0;
    int tick_seen = 0;

    function automatic int bcd2int(input logic [11:0] v);
        int r = 0;
        if ($isunknown(v)) return -1;
        for (int i = 2; i >= 0; i--) begin
            if (v[4*i +: 4] > 4'd9) return -1;
            r = r * 10 + int'(v[4*i +: 4]);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input int exp);
        checks++;
        assert (act === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_score = 0; m_high = 0; m_div = 0;
    endtask

    // One clock: drive inputs, check tick, push expectation, compare after edge.
    task automatic step(input logic a, input logic p, input logic bv,
                        input int ba, input logic ch, input logic sh);
        int s, ns, nst, nd, nh, inc;
        bit tk, upd;
        exp_t e;
        alive = a; pause = p; bonus_valid = bv;
        bonus_amt = 4'(ba); clear_high = ch; show_high = sh;
        #1;
        tk = (m_st == 1) && !p && (m_div == 3);
        chk("tick", tick, int'(tk));
        if (tk) tick_seen++;
        nst = m_st; ns = m_score; nd = 0; upd = 0; s = m_score;
        if (m_st == 1) begin
            inc = int'(tk) + (bv ? ((ba > 9) ? 9 : ba) : 0);
            s = m_score + inc;
            if (s > 999) s = 999;
            ns = s;
            nd = p ? m_div : (tk ? 0 : m_div + 1);
            if (!a) begin
                nst = 2;
                upd = (s > m_high);
            end
        end else if (a) begin
            nst = 1;
            ns = 0;
        end
        nh = ch ? 0 : (upd ? s : m_high);
        sb.push_back('{nst, ns, nh, int'(upd && !ch)});
        m_st = nst; m_score = ns; m_div = nd; m_high = nh;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("state", state, e.st);
        chk("score", bcd2int(score_bcd), e.score);
        chk("high", bcd2int(high_bcd), e.high);
        chk("new_high", new_high, e.nh);
        chk("saturated", saturated, int'(e.score == 999));
        chk("disp", bcd2int(disp_bcd), sh ? e.high : e.score);
    endtask

    task automatic bonus_to(input int target);
        while (m_score < target)
            step(1, 1, 1, ((target - m_score) > 9) ? 9 : (target - m_score), 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_score"}, score_bcd, 0);
        chk({tag, "_high"}, high_bcd, 0);
        chk({tag, "_tick"}, tick, 0);
        chk({tag, "_new_high"}, new_high, 0);
        chk({tag, "_sat"}, saturated, 0);
    endtask

    initial begin
        int t0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;
        model_reset();

        // 41 alive cycles: one IDLE->RUN cycle then 10 ticks
        t0 = tick_seen;
        repeat (41) step(1, 0, 0, 0, 0, 0);
        chk("run_ticks", tick_seen - t0, 10);
        chk("run_score", score_bcd, 'h010);
        chk("run_state", state, 1);

        // 095 + tick + bonus 7 -> 103
        bonus_to(95);
        while (m_div != 3) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 7, 0, 0);
        chk("carry_103", score_bcd, 'h103);

        // bonus 12 clamps to 9
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 12, 0, 0);
        chk("clamp_009", score_bcd, 'h009);

        // saturation at 999
        bonus_to(996);
        step(1, 1, 1, 9, 0, 0);
        chk("sat_999", score_bcd, 'h999);
        chk("sat_flag", saturated, 1);
        repeat (8) step(1, 0, 0, 0, 0, 0);
        chk("sat_hold", score_bcd, 'h999);

        // high 030, then score 042 beats it
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        chk("clr_over", high_bcd, 0);
        step(1, 0, 0, 0, 0, 0);
        bonus_to(30);
        step(0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        bonus_to(42);
        step(0, 1, 0, 0, 0, 1);
        chk("hs_state", state, 2);
        chk("hs_042", high_bcd, 'h042);
        chk("hs_pulse", new_high, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("hs_pulse_end", new_high, 0);
        step(1, 0, 0, 0, 0, 0);
        bonus_to(42);
        step(0, 1, 0, 0, 0, 0);
        chk("eq_high", high_bcd, 'h042);
        chk("eq_no_pulse", new_high, 0);

        // pause freezes divider mid-count
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        t0 = tick_seen;
        repeat (20) step(1, 1, 0, 0, 0, 0);
        chk("pause_ticks", tick_seen - t0, 0);
        chk("pause_score", score_bcd, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("resume_early", tick_seen - t0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("resume_tick", tick_seen - t0, 1);
        chk("resume_score", score_bcd, 'h001);

        // clear_high wins over a game-over update
        bonus_to(50);
        step(0, 1, 0, 0, 1, 0);
        chk("clr_win_high", high_bcd, 0);
        chk("clr_win_nh", new_high, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("clr_win_nh2", new_high, 0);

        // asynchronous reset mid-RUN
        step(1, 0, 0, 0, 0, 0);
        bonus_to(20);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        bonus_to(20);
        chk("pre_rst_high", high_bcd, 'h020);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("post_rst_idle", state, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("post_rst_run", state, 1);
        chk("post_rst_high", high_bcd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_score_tracker.md
BCD_SCORE_TRACKER -- requirements
Module: bcd_score_tracker

Interface
REQ-001 SHALL have parameter DIGITS, default 3, number of BCD score digits (1..8).
REQ-002 SHALL have parameter TICK_DIV, default 25_000_000, clk cycles per score tick (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port alive  input  1  game running level from game engine.
REQ-006 SHALL have port pause  input  1  freezes tick divider and tick scoring while high.
REQ-007 SHALL have port bonus_valid  input  1  one-cycle bonus add request.
REQ-008 SHALL have port bonus_amt  input  4  bonus points, binary; values >9 clamp to 9.
REQ-009 SHALL have port clear_high  input  1  clears high score.
REQ-010 SHALL have port show_high  input  1  selects high score onto disp_bcd.
REQ-011 SHALL have port score_bcd  output  4*DIGITS  current score, digit 0 in bits [3:0].
REQ-012 SHALL have port high_bcd  output  4*DIGITS  high score, same packing.
REQ-013 SHALL have port disp_bcd  output  4*DIGITS  show_high ? high_bcd : score_bcd, combinational.
REQ-014 SHALL have port tick  output  1  one-cycle pulse per divider wrap.
REQ-015 SHALL have port new_high  output  1  one-cycle pulse when high score updated.
REQ-016 SHALL have port saturated  output  1  high while score equals all 9s.
REQ-017 SHALL have port state  output  2  FSM state: 0 IDLE, 1 RUN, 2 OVER.

Function
REQ-018 FSM SHALL be IDLE -> RUN when alive=1; RUN -> OVER when alive=0; OVER -> RUN when alive=1; IDLE holds while alive=0.
REQ-019 Entering RUN from IDLE or OVER SHALL clear score and divider in the transition cycle.
REQ-020 Divider SHALL count only in RUN with pause=0; it SHALL hold its value while paused and clear outside RUN.
REQ-021 When divider equals TICK_DIV-1 it SHALL wrap to 0 and pulse tick for exactly that one cycle.
REQ-022 In RUN, score SHALL increase by tick + min(bonus_amt,9)*bonus_valid each cycle (max +10), evaluated as BCD add with carry ripple across all DIGITS.
REQ-023 bonus_valid SHALL be honoured while pause=1 in RUN and ignored in IDLE and OVER.
REQ-024 Sums exceeding all-9s SHALL saturate the score at all-9s; no wrap-around.
REQ-025 Score SHALL hold its value in OVER until the next RUN entry.
REQ-026 On the RUN -> OVER transition cycle, if score (post-update) > high_bcd strictly, high_bcd SHALL load score and new_high SHALL pulse one cycle later for one cycle.
REQ-027 Equal score SHALL NOT update high_bcd nor pulse new_high.
REQ-028 clear_high SHALL zero high_bcd next cycle in any state; clear_high coincident with an update SHALL win (high_bcd=0, no new_high).
REQ-029 Every BCD digit output SHALL always be in 0..9.
REQ-030 saturated SHALL be registered and derived from the score register, no extra latency beyond score.

Reset
REQ-031 reset_n=0 SHALL asynchronously force state=IDLE, score=0, high=0, divider=0, tick=0, new_high=0, saturated=0.
REQ-032 Reset asserted mid-game SHALL discard score and high score; after release, operation resumes from IDLE.

Verification
REQ-033 TICK_DIV=4, DIGITS=3: reset, alive=1 for 41 cycles -> tick every 4th cycle, score_bcd=010 after 10 ticks, state=RUN.
REQ-034 Score 095, bonus_valid=1 bonus_amt=7 same cycle as tick -> score 103 next cycle; bonus_amt=12 from 000 -> 009.
REQ-035 Score 996, bonus 9 -> score 999, saturated=1; further ticks leave 999.
REQ-036 Score 042 high 030, alive falls -> state OVER, high_bcd=042, new_high pulse one cycle; replay to 042 and end -> no update, no pulse.
REQ-037 pause=1 for 20 cycles in RUN -> no tick, divider value unchanged, score unchanged; release -> tick resumes from held count.
REQ-038 clear_high asserted on the RUN -> OVER cycle with score>high -> high_bcd=000, new_high never pulses; reset_n low mid-RUN -> all outputs 0 immediately.
